mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_rdata_hold.sv | 49 ++++
 rtl/mem_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - pipeline bus widths and field layouts shared by all stages
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_W = 71;
   localparam int MS_TO_WS_BUS_W = 70;
   localparam int FWD_BUS_W      = 39;

   // Field order is MSB first; these structs are the authoritative bit layouts.
   typedef struct packed {
      logic        res_from_mem;   // [70]
      logic        gr_we;          // [69]
      logic [4:0]  dest;           // [68:64]
      logic [31:0] alu_result;     // [63:32]
      logic [31:0] pc;             // [31:0]
   } es_to_ms_t;

   typedef struct packed {
      logic        gr_we;          // [69]
      logic [4:0]  dest;           // [68:64]
      logic [31:0] final_result;   // [63:32]
      logic [31:0] pc;             // [31:0]
   } ms_to_ws_t;

   typedef struct packed {
      logic        fwd_we;         // [38]
      logic        fwd_is_load;    // [37]
      logic [4:0]  dest;           // [36:32]
      logic [31:0] final_result;   // [31:0]
   } ms_fwd_t;

endpackage

// File: rtl/mem_rdata_hold.sv
// rtl/mem_rdata_hold.sv - captures SRAM read data in an instruction's first MEM cycle and holds it across WB stalls
module mem_rdata_hold
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        capture_i,
   input  logic        leave_i,
   input  logic        ms_valid_i,
   input  logic        ws_allowin_i,
   input  logic [31:0] data_sram_rdata_i,
   output logic [31:0] load_data_o
);

   logic        first_cycle_q, first_cycle_d;
   logic        rdata_held_q,  rdata_held_d;
   logic [31:0] rdata_buf_q,   rdata_buf_d;
   logic        hold_now;

   // SRAM data is only valid in the first cycle, so a stall then must snapshot it.
   assign hold_now = first_cycle_q && ms_valid_i && !ws_allowin_i;

   always_comb begin
      first_cycle_d = capture_i;
      rdata_held_d  = rdata_held_q;
      rdata_buf_d   = rdata_buf_q;
      if (capture_i || leave_i) begin
         rdata_held_d = 1'b0;
      end else if (hold_now) begin
         rdata_held_d = 1'b1;
         rdata_buf_d  = data_sram_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         first_cycle_q <= 1'b0;
         rdata_held_q  <= 1'b0;
         rdata_buf_q   <= 32'h0;
      end else begin
         first_cycle_q <= first_cycle_d;
         rdata_held_q  <= rdata_held_d;
         rdata_buf_q   <= rdata_buf_d;
      end
   end

   assign load_data_o = rdata_held_q ? rdata_buf_q : data_sram_rdata_i;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: handshake, bus register, load result select and ID forwarding
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ES_TO_MS_BUS_W = mem_stage_pkg::ES_TO_MS_BUS_W,
   parameter int MS_TO_WS_BUS_W = mem_stage_pkg::MS_TO_WS_BUS_W,
   parameter int FWD_BUS_W      = mem_stage_pkg::FWD_BUS_W
)(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
   output logic                      ms_allowin,
   input  logic [31:0]               data_sram_rdata,
   input  logic                      ws_allowin,
   output logic                      ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
   output logic [FWD_BUS_W-1:0]      ms_fwd_bus
);

   logic                      ms_valid_q, ms_valid_d;
   logic [ES_TO_MS_BUS_W-1:0] bus_q,      bus_d;
   logic                      ms_ready_go;
   logic                      capture;
   logic                      leave;
   logic [31:0]               load_data;
   logic [31:0]               final_result;
   es_to_ms_t                 es;
   ms_to_ws_t                 ws_out;
   ms_fwd_t                   fwd_out;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
   assign capture        = es_to_ms_valid && ms_allowin;
   assign leave          = ms_to_ws_valid && ws_allowin;

   always_comb begin
      ms_valid_d = ms_valid_q;
      bus_d      = bus_q;
      if (ms_allowin) ms_valid_d = es_to_ms_valid;
      if (capture)    bus_d      = es_to_ms_bus;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q <= 1'b0;
         bus_q      <= '0;
      end else begin
         ms_valid_q <= ms_valid_d;
         bus_q      <= bus_d;
      end
   end

   mem_rdata_hold u_rdata_hold (
      .clk               (clk),
      .resetn            (resetn),
      .capture_i         (capture),
      .leave_i           (leave),
      .ms_valid_i        (ms_valid_q),
      .ws_allowin_i      (ws_allowin),
      .data_sram_rdata_i (data_sram_rdata),
      .load_data_o       (load_data)
   );

   assign es           = bus_q;
   assign final_result = es.res_from_mem ? load_data : es.alu_result;

   // Bus fields stay visible while invalid; consumers qualify them with the valid bits.
   always_comb begin
      ws_out.gr_we         = es.gr_we;
      ws_out.dest          = es.dest;
      ws_out.final_result  = final_result;
      ws_out.pc            = es.pc;
      fwd_out.fwd_we       = ms_valid_q && es.gr_we && (es.dest != 5'd0);
      fwd_out.fwd_is_load  = ms_valid_q && es.res_from_mem;
      fwd_out.dest         = es.dest;
      fwd_out.final_result = final_result;
   end

   assign ms_to_ws_bus = ws_out;
   assign ms_fwd_bus   = fwd_out;

endmodule
